// File: rtl/alu_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode classification
// used by the ALU sequencer and by the ALU that consumes its operands.
package alu_pkg;

  localparam int unsigned OP_ADD   = 3;
  localparam int unsigned OP_SUB   = 4;
  localparam int unsigned OP_AND   = 5;
  localparam int unsigned OP_OR    = 6;
  localparam int unsigned OP_XOR   = 7;
  localparam int unsigned OP_MUL   = 15;
  localparam int unsigned OP_DIV   = 16;
  localparam int unsigned OP_BR    = 19;
  localparam int unsigned OP_MFHI  = 24;
  localparam int unsigned OP_MFLO  = 25;
  localparam int unsigned OP_NOP   = 26;

  // Opcodes in this range take their result from the ALU.
  localparam int unsigned ALU_FIRST = 3;
  localparam int unsigned ALU_LAST  = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB,
    ST_DONE
  } state_e;

  // How an opcode is handled once it has been accepted.
  typedef enum logic [2:0] {
    CLS_ALU_WR,  // ALU result written to the general register file
    CLS_HILO,    // ALU result (mul/div) written to HI/LO
    CLS_MFHI,    // HI moved to the general register file
    CLS_MFLO,    // LO moved to the general register file
    CLS_NOP,     // completes without any write
    CLS_BAD      // unsupported: error pulse, no write
  } op_class_e;

  function automatic op_class_e classify(input int unsigned op);
    if (op == OP_MUL || op == OP_DIV)           return CLS_HILO;
    if (op >= ALU_FIRST && op <= ALU_LAST)      return CLS_ALU_WR;
    if (op == OP_MFHI)                          return CLS_MFHI;
    if (op == OP_MFLO)                          return CLS_MFLO;
    if (op == OP_NOP)                           return CLS_NOP;
    return CLS_BAD;
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair: loads both halves of a double-width word together.
module hilo_reg #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            we,
  input  logic [2*DW-1:0] din,
  output logic [DW-1:0]   hi,
  output logic [DW-1:0]   lo
);

  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  // Next-value selection: load on write enable, otherwise hold.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we) begin
      hi_d = din[2*DW-1:DW];
      lo_d = din[DW-1:0];
    end
  end

  // HI/LO storage with asynchronous clear.
  always_ff @(posedge clk or negedge clr) begin
    // NOTE: clr acts immediately, independent of clk; every register here is
    // an ordinary flop (not a RAM), so clearing all of them is legal and cheap.
    if (!clr) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/alu_sequencer.sv
// Four-state sequencer: latches an operation, presents it to an external
// combinational ALU, captures the result and writes it back to either the
// general register file or the HI/LO pair.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DW  = 32,
  parameter int OPW = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [OPW-1:0]  opcode,
  input  logic [DW-1:0]   ra_data,
  input  logic [DW-1:0]   rb_data,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [2*DW-1:0] alu_c,
  output logic [DW-1:0]   rz_data,
  output logic            rz_we,
  output logic [DW-1:0]   hi_out,
  output logic [DW-1:0]   lo_out,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e          state_q, state_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [2*DW-1:0] z_q, z_d;

  op_class_e       op_cls;
  logic            hilo_we;
  logic [DW-1:0]   hi_w;
  logic [DW-1:0]   lo_w;

  assign op_cls = classify(32'(op_q));

  // Next-state, operand latching, Z capture and per-state output strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    z_d     = z_q;
    busy    = 1'b0;
    done    = 1'b0;
    rz_we   = 1'b0;
    err     = 1'b0;
    hilo_we = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EXEC;
          a_d     = ra_data;
          b_d     = rb_data;
          op_d    = opcode;
        end
      end
      ST_EXEC: begin
        busy    = 1'b1;
        state_d = ST_WB;
        case (op_cls)
          CLS_ALU_WR, CLS_HILO: z_d = alu_c;
          CLS_MFHI:             z_d = {{DW{1'b0}}, hi_w};
          CLS_MFLO:             z_d = {{DW{1'b0}}, lo_w};
          default:              z_d = z_q;
        endcase
      end
      ST_WB: begin
        busy    = 1'b1;
        state_d = ST_DONE;
        rz_we   = (op_cls == CLS_ALU_WR) || (op_cls == CLS_MFHI) ||
                  (op_cls == CLS_MFLO);
        hilo_we = (op_cls == CLS_HILO);
        err     = (op_cls == CLS_BAD);
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched operation and Z register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      z_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the values
      // present before the edge, independent of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      z_q     <= z_d;
    end
  end

  hilo_reg #(.DW(DW)) u_hilo (
    .clk (clk),
    .clr (clr),
    .we  (hilo_we),
    .din (z_q),
    .hi  (hi_w),
    .lo  (lo_w)
  );

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = op_q;
  assign rz_data = z_q[DW-1:0];
  assign hi_out  = hi_w;
  assign lo_out  = lo_w;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a vector table of single operations plus
// hand-written sequences for held start and reset during execution.
module tb_alu_sequencer;

  localparam int DW  = 32;
  localparam int OPW = 5;

  logic            clk = 1'b0;
  logic            clr;
  logic            start;
  logic [OPW-1:0]  opcode;
  logic [DW-1:0]   ra_data;
  logic [DW-1:0]   rb_data;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [OPW-1:0]  alu_op;
  logic [2*DW-1:0] alu_c;
  logic [DW-1:0]   rz_data;
  logic            rz_we;
  logic [DW-1:0]   hi_out;
  logic [DW-1:0]   lo_out;
  logic            busy;
  logic            done;
  logic            err;

  int n_pass  = 0;
  int n_total = 0;

  alu_sequencer #(.DW(DW), .OPW(OPW)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .opcode  (opcode),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_c   (alu_c),
    .rz_data (rz_data),
    .rz_we   (rz_we),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Reference ALU: unlisted opcodes return {b, a} so a wrong source is visible.
  always_comb begin
    alu_c = {alu_b, alu_a};
    case (alu_op)
      5'd3:  alu_c = {32'd0, alu_a + alu_b};
      5'd4:  alu_c = {32'd0, alu_a - alu_b};
      5'd5:  alu_c = {32'd0, alu_a & alu_b};
      5'd6:  alu_c = {32'd0, alu_a | alu_b};
      5'd7:  alu_c = {32'd0, alu_a ^ alu_b};
      5'd15: alu_c = {32'd0, alu_a} * {32'd0, alu_b};
      5'd16: alu_c = (alu_b != 0) ? {alu_a % alu_b, alu_a / alu_b} : 64'd0;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Issues one operation and records per-cycle strobes for the four cycles
  // after the accepting edge (bit 0 = first cycle after accept). Inputs are
  // scrambled right after the accept to show they are no longer used.
  task automatic run_op(input logic [4:0] op, input logic [31:0] ra,
                        input logic [31:0] rb,
                        output logic [3:0] we_m, output logic [3:0] err_m,
                        output logic [3:0] done_m, output logic [3:0] busy_m,
                        output logic [31:0] rz, output logic [4:0] op_exec);
    we_m = '0; err_m = '0; done_m = '0; busy_m = '0; rz = '0; op_exec = '0;
    @(negedge clk);
    start = 1'b1; opcode = op; ra_data = ra; rb_data = rb;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start   = 1'b0;
        op_exec = alu_op;
        ra_data = $urandom;
        rb_data = $urandom;
        opcode  = 5'($urandom);
      end
      we_m[c]   = rz_we;
      err_m[c]  = err;
      done_m[c] = done;
      busy_m[c] = busy;
      if (rz_we) rz = rz_data;
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        exp_we;
    logic        exp_err;
    logic [31:0] exp_rz;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [3:0]  we_m, err_m, done_m, busy_m;
    logic [31:0] rz;
    logic [4:0]  op_exec;
    logic [7:0]  we8, done8, busy8;
    logic [31:0] rz_seen;

    //            op     ra            rb            we    err   rz            hi    lo
    vecs[0]  = '{5'd3,  32'd5,        32'd7,        1'b1, 1'b0, 32'd12,       32'd0, 32'd0};
    vecs[1]  = '{5'd15, 32'h00010000, 32'h00010000, 1'b0, 1'b0, 32'd0,        32'd1, 32'd0};
    vecs[2]  = '{5'd24, 32'h0000dead, 32'h0000beef, 1'b1, 1'b0, 32'd1,        32'd1, 32'd0};
    vecs[3]  = '{5'd25, 32'h0000dead, 32'h0000beef, 1'b1, 1'b0, 32'd0,        32'd1, 32'd0};
    vecs[4]  = '{5'd4,  32'd3,        32'd5,        1'b1, 1'b0, 32'hFFFFFFFE, 32'd1, 32'd0};
    vecs[5]  = '{5'd19, 32'd1,        32'd2,        1'b0, 1'b1, 32'd0,        32'd1, 32'd0};
    vecs[6]  = '{5'd16, 32'd17,       32'd5,        1'b0, 1'b0, 32'd0,        32'd2, 32'd3};
    vecs[7]  = '{5'd24, 32'd9,        32'd9,        1'b1, 1'b0, 32'd2,        32'd2, 32'd3};
    vecs[8]  = '{5'd26, 32'd4,        32'd4,        1'b0, 1'b0, 32'd0,        32'd2, 32'd3};
    vecs[9]  = '{5'd7,  32'h000000F0, 32'h000000FF, 1'b1, 1'b0, 32'h0000000F, 32'd2, 32'd3};
    vecs[10] = '{5'd31, 32'd6,        32'd6,        1'b0, 1'b1, 32'd0,        32'd2, 32'd3};
    vecs[11] = '{5'd0,  32'd6,        32'd6,        1'b0, 1'b1, 32'd0,        32'd2, 32'd3};
    vecs[12] = '{5'd18, 32'h00000011, 32'h00000022, 1'b1, 1'b0, 32'h00000011, 32'd2, 32'd3};
    vecs[13] = '{5'd5,  32'hFF00FF00, 32'h0FF00FF0, 1'b1, 1'b0, 32'h0F000F00, 32'd2, 32'd3};

    // Reset state, observed before any active edge matters.
    clr = 1'b0; start = 1'b0; opcode = '0; ra_data = '0; rb_data = '0;
    #12;
    check("reset busy",    busy,    0);
    check("reset done",    done,    0);
    check("reset rz_we",   rz_we,   0);
    check("reset err",     err,     0);
    check("reset alu_a",   alu_a,   0);
    check("reset alu_op",  alu_op,  0);
    check("reset hi_out",  hi_out,  0);
    check("reset lo_out",  lo_out,  0);
    check("reset rz_data", rz_data, 0);
    @(negedge clk);
    clr = 1'b1;

    // Table of single operations.
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].ra, vecs[i].rb,
             we_m, err_m, done_m, busy_m, rz, op_exec);
      check($sformatf("v%0d op%0d alu_op in EXEC", i, vecs[i].op), op_exec, vecs[i].op);
      check($sformatf("v%0d op%0d rz_we timing", i, vecs[i].op), we_m,
            vecs[i].exp_we ? 4'b0010 : 4'b0000);
      check($sformatf("v%0d op%0d err timing", i, vecs[i].op), err_m,
            vecs[i].exp_err ? 4'b0010 : 4'b0000);
      check($sformatf("v%0d op%0d done timing", i, vecs[i].op), done_m, 4'b0100);
      check($sformatf("v%0d op%0d busy timing", i, vecs[i].op), busy_m, 4'b0011);
      if (vecs[i].exp_we)
        check($sformatf("v%0d op%0d rz_data", i, vecs[i].op), rz, vecs[i].exp_rz);
      check($sformatf("v%0d op%0d hi_out", i, vecs[i].op), hi_out, vecs[i].exp_hi);
      check($sformatf("v%0d op%0d lo_out", i, vecs[i].op), lo_out, vecs[i].exp_lo);
      check($sformatf("v%0d op%0d alu_op held", i, vecs[i].op), alu_op, vecs[i].op);
    end

    // start held high through an add 1+1: one op per accept, next accept in IDLE.
    we8 = '0; done8 = '0; busy8 = '0; rz_seen = '0;
    @(negedge clk);
    start = 1'b1; opcode = 5'd3; ra_data = 32'd1; rb_data = 32'd1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      we8[c]   = rz_we;
      done8[c] = done;
      busy8[c] = busy;
      if (rz_we) rz_seen = rz_data;
    end
    start = 1'b0;
    check("held start rz_we pattern", we8,   8'b0010_0010);
    check("held start done pattern",  done8, 8'b0100_0100);
    check("held start busy pattern",  busy8, 8'b0011_0011);
    check("held start rz_data",       rz_seen, 32'd2);

    // Reset in the middle of EXEC of a div.
    @(negedge clk);
    start = 1'b1; opcode = 5'd16; ra_data = 32'd100; rb_data = 32'd7;
    @(posedge clk);
    #2;
    start = 1'b0;
    check("div in EXEC before reset", busy, 1);
    clr = 1'b0;
    #1;
    check("mid-EXEC reset busy",   busy,   0);
    check("mid-EXEC reset done",   done,   0);
    check("mid-EXEC reset rz_we",  rz_we,  0);
    check("mid-EXEC reset hi_out", hi_out, 0);
    check("mid-EXEC reset lo_out", lo_out, 0);
    check("mid-EXEC reset alu_op", alu_op, 0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    we_m = '0; done_m = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      we_m[c]   = rz_we;
      done_m[c] = done;
    end
    check("post-reset no rz_we", we_m,   4'b0000);
    check("post-reset no done",  done_m, 4'b0000);

    // Ready again after reset release.
    run_op(5'd3, 32'd20, 32'd22, we_m, err_m, done_m, busy_m, rz, op_exec);
    check("after reset add rz_we", we_m,   4'b0010);
    check("after reset add done",  done_m, 4'b0100);
    check("after reset add rz",    rz,     32'd42);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DW, default 32, meaning operand/register data width.
REQ-002 SHALL have parameter OPW, default 5, meaning opcode width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port clr  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request strobe; sampled only in IDLE.
REQ-006 SHALL have port opcode  input  OPW  operation code, ALU encoding.
REQ-007 SHALL have port ra_data  input  DW  first operand.
REQ-008 SHALL have port rb_data  input  DW  second operand or immediate.
REQ-009 SHALL have port alu_a  output  DW  ALU A operand, from internal register.
REQ-010 SHALL have port alu_b  output  DW  ALU B operand, from internal register.
REQ-011 SHALL have port alu_op  output  OPW  ALU opcode, from internal register.
REQ-012 SHALL have port alu_c  input  2*DW  combinational ALU result.
REQ-013 SHALL have port rz_data  output  DW  writeback data, low word of Z.
REQ-014 SHALL have port rz_we  output  1  one-cycle general-register write strobe.
REQ-015 SHALL have port hi_out, lo_out  output  DW each  internal HI/LO register contents.
REQ-016 SHALL have port busy  output  1  high in EXEC and WB.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port err  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-019 SHALL implement FSM states IDLE, EXEC, WB, DONE; transitions IDLE->EXEC on start, EXEC->WB, WB->DONE, DONE->IDLE, all unconditional except IDLE.
REQ-020 SHALL, on the edge sampling start=1 in IDLE, register opcode, ra_data and rb_data; later input changes have no effect until the next accept.
REQ-021 SHALL ignore start in EXEC, WB and DONE: no queuing, no error.
REQ-022 SHALL drive alu_a/alu_b/alu_op from the latched values in all states; they hold their value after completion.
REQ-023 SHALL capture 2*DW Z register at the end of EXEC: alu_c for opcodes 3..18; {0,HI} for mfhi (24); {0,LO} for mflo (25).
REQ-024 SHALL, in WB, pulse rz_we=1 with rz_data=Z[DW-1:0] for opcodes 3..14, 17, 18, 24 and 25.
REQ-025 SHALL, in WB for mul (15) and div (16), load HI=Z[2DW-1:DW] and LO=Z[DW-1:0] and keep rz_we=0.
REQ-026 SHALL treat nop (26) as a no-write operation that still completes through DONE.
REQ-027 SHALL treat every other opcode as unsupported: err=1 in WB, no rz_we, HI/LO unchanged, and completion through DONE.
REQ-028 SHALL assert done=1 only in DONE: exactly 3 edges after the accepting edge, and for exactly one cycle.
REQ-029 SHALL accept the next start no earlier than the first IDLE cycle after DONE, giving a minimum issue interval of 4 cycles.
REQ-030 SHALL keep rz_data equal to Z low word continuously; it is valid when rz_we=1.

Reset
REQ-031 SHALL, while clr=0, force state IDLE, all registers (operands, opcode, Z, HI, LO) to 0, and busy, done, rz_we and err to 0, regardless of clk.
REQ-032 SHALL abort any in-flight operation on reset without producing a write strobe or done; after release it is in IDLE and ready for start.

Structure
REQ-033 SHALL take opcode constants and the state enumeration from shared package alu_pkg, which the ALU also uses.
REQ-034 SHALL isolate HI/LO storage in one sub-module, hilo_reg, with clk, clr, we, a 2*DW data input and hi/lo outputs.

Verification
REQ-035 Add (3), ra=5, rb=7: alu_op=3 in EXEC; rz_we=1 with rz_data=12 at edge+2; done at edge+3.
REQ-036 Mul (15), ra=rb=0x00010000: rz_we stays 0; HI=0x00000001, LO=0x00000000 after WB. A following mfhi (24) gives rz_data=1.
REQ-037 Start reasserted every cycle during add 1+1: only one operation runs; next accept happens in IDLE; exactly one done per accept.
REQ-038 Opcode 19 (br): err pulse in WB; no rz_we; HI/LO unchanged; done still pulses.
REQ-039 clr=0 asserted mid-EXEC of div: immediate IDLE; busy=0; no rz_we or done; HI=LO=0.
REQ-040 Sub (4), ra=3, rb=5: rz_data=0xFFFFFFFE; ra_data changed during EXEC does not alter the result.
